// File: rtl/demux1_n_pipe_if.sv
// Handshake bundle for demux1_n_pipe: one input stream, NOUT output channels.
// master = producer/consumer side, slave = the demux itself.
interface demux1_n_pipe_if #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 2
);
    localparam int NOUT = 1 << SEL_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      in_sel;
    logic [WIDTH-1:0]      in_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;
    logic [NOUT*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux1_n_pipe.sv
// Registered 1-to-N demultiplexer with per-channel single-entry holding
// registers and independent back-pressure.
// Optional: define DEMUX1_N_PIPE_CNT_EN to add per-channel 8-bit counters of
// accepted beats on port acc_cnt (wrap at 255, survive flush).

// One output channel: single-entry holding register (+ optional counter).
module demux1_n_pipe_chan #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] ld_data,
    output logic             full,
    output logic [WIDTH-1:0] data
`ifdef DEMUX1_N_PIPE_CNT_EN
    ,
    output logic [7:0]       cnt
`endif
);
    // Occupancy: flush beats everything; a load covers drain+refill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Payload only moves on a load, so it is stable while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (load) begin
            data <= ld_data;
        end
    end

`ifdef DEMUX1_N_PIPE_CNT_EN
    // Accepted-beat counter; load never fires during flush, and flush does
    // not clear it, so flushed beats stay counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= cnt + 8'd1;
        end
    end
`endif
endmodule

module demux1_n_pipe #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    demux1_n_pipe_if.slave       bus
`ifdef DEMUX1_N_PIPE_CNT_EN
    ,
    output logic [(1<<SEL_W)*8-1:0] acc_cnt
`endif
);
    localparam int NOUT = 1 << SEL_W;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } req_t;

    req_t                        req;
    logic                        in_ready;
    logic                        accept;
    logic [NOUT-1:0]             full_q;
    logic [NOUT-1:0]             load;
    logic [NOUT-1:0]             drain;
    logic [NOUT-1:0][WIDTH-1:0]  data_q;
`ifdef DEMUX1_N_PIPE_CNT_EN
    logic [NOUT-1:0][7:0]        cnt_q;
`endif

    assign req = '{sel: bus.in_sel, data: bus.in_data};

    // Ready looks only at the selected channel: it can take a beat if empty
    // or being drained this cycle. Held low during reset and flush.
    assign in_ready = reset_n & ~flush & (~full_q[req.sel] | bus.out_ready[req.sel]);
    assign accept   = bus.in_valid & in_ready;

    // One-hot load strobe to the selected channel.
    always_comb begin
        load = '0;
        if (accept) begin
            load[req.sel] = 1'b1;
        end
    end

    assign drain = full_q & bus.out_ready;

    for (genvar k = 0; k < NOUT; k++) begin : g_chan
        demux1_n_pipe_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .load    (load[k]),
            .drain   (drain[k]),
            .ld_data (req.data),
            .full    (full_q[k]),
            .data    (data_q[k])
`ifdef DEMUX1_N_PIPE_CNT_EN
            ,
            .cnt     (cnt_q[k])
`endif
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full_q;
    assign bus.out_data  = data_q;
`ifdef DEMUX1_N_PIPE_CNT_EN
    assign acc_cnt       = cnt_q;
`endif
endmodule

// File: tb/tb_demux1_n_pipe.sv
// Randomized + directed bench for demux1_n_pipe against a queue-per-channel
// reference model (each channel is a FIFO of capacity one).
module tb_demux1_n_pipe;
    localparam int WIDTH = 64;
    localparam int SEL_W = 2;
    localparam int NOUT  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
`ifdef DEMUX1_N_PIPE_CNT_EN
    logic [NOUT*8-1:0] acc_cnt;
`endif

    demux1_n_pipe_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    demux1_n_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
`ifdef DEMUX1_N_PIPE_CNT_EN
        ,
        .acc_cnt (acc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue per channel holding at most one beat.
    logic [WIDTH-1:0] mq [NOUT][$];
    logic [7:0]       mcnt [NOUT];

    function automatic logic [NOUT-1:0] exp_valid();
        logic [NOUT-1:0] v;
        for (int k = 0; k < NOUT; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    function automatic logic exp_ready();
        if (flush) return 1'b0;
        return (mq[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel];
    endfunction

    // Advance one clock from negedge to negedge and update the model.
    task automatic cycle();
        logic acc;
        logic [SEL_W-1:0] s;
        logic [WIDTH-1:0] d;
        acc = bus.in_valid && exp_ready();
        s = bus.in_sel;
        d = bus.in_data;
        @(posedge clk);
        for (int k = 0; k < NOUT; k++) begin
            if (flush) mq[k].delete();
            else if (mq[k].size() != 0 && bus.out_ready[k]) void'(mq[k].pop_front());
        end
        if (acc) begin
            mq[s].push_back(d);
            mcnt[s] = mcnt[s] + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            mq[k].delete();
            mcnt[k] = 8'd0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = {$urandom, $urandom};
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_prefill out_valid=%b exp=%b", bus.out_valid, 4'b0100);
        end
        // assert reset mid-cycle, away from any edge
        #2 reset_n = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            mq[k].delete();
            mcnt[k] = 8'd0;
        end
        #1;
        n_vec++;
        if (bus.out_valid !== 4'b0000 || bus.out_data !== '0) begin
            n_err++;
            $display("FAIL reset_async out_valid=%b out_data=%h exp 0", bus.out_valid, bus.out_data);
        end
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        cycle();
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle out_valid=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_single();
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 64'hA5;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_rdy got=%b exp=1", bus.in_ready);
        end
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[64 +: 64] !== 64'hA5) begin
            n_err++;
            $display("FAIL single_out valid=%b slice1=%h exp 0010/a5", bus.out_valid, bus.out_data[64 +: 64]);
        end
        bus.in_data = 64'h5A;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_full_rdy got=%b exp=0", bus.in_ready);
        end
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[64 +: 64] !== 64'hA5) begin
            n_err++;
            $display("FAIL single_hold valid=%b slice1=%h exp 0010/a5", bus.out_valid, bus.out_data[64 +: 64]);
        end
        bus.out_ready = 4'b0010;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_drain_rdy got=%b exp=1", bus.in_ready);
        end
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[64 +: 64] !== 64'h5A) begin
            n_err++;
            $display("FAIL single_refill valid=%b slice1=%h exp 0010/5a", bus.out_valid, bus.out_data[64 +: 64]);
        end
        bus.in_valid = 1'b0;
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL single_empty valid=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d0;
        idle_inputs();
        d0 = {$urandom, $urandom};
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = d0;
        cycle();
        bus.in_sel  = 2'd3;
        bus.in_data = 64'h7;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_rdy got=%b exp=1", bus.in_ready);
        end
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b1001 || bus.out_data[192 +: 64] !== 64'h7 || bus.out_data[0 +: 64] !== d0) begin
            n_err++;
            $display("FAIL bp_out valid=%b s3=%h s0=%h exp 1001/7/%h", bus.out_valid,
                     bus.out_data[192 +: 64], bus.out_data[0 +: 64], d0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        cycle();
    endtask

    task automatic test_streaming();
        idle_inputs();
        bus.out_ready = 4'b0100;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        for (int i = 1; i <= 8; i++) begin
            bus.in_data = 64'(i);
            #1;
            n_vec++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_rdy beat=%0d got=%b exp=1", i, bus.in_ready);
            end
            cycle();
            n_vec++;
            if (bus.out_valid !== 4'b0100 || bus.out_data[128 +: 64] !== 64'(i)) begin
                n_err++;
                $display("FAIL stream_out beat=%0d valid=%b s2=%h exp 0100/%0d", i, bus.out_valid,
                         bus.out_data[128 +: 64], i);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL stream_end valid=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 64'h11;
        cycle();
        bus.in_sel   = 2'd1;
        bus.in_data  = 64'h22;
        cycle();
        bus.in_sel   = 2'd2;
        bus.in_data  = 64'h33;
        flush        = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0011) begin
            n_err++;
            $display("FAIL flush_cycle rdy=%b valid=%b exp 0/0011", bus.in_ready, bus.out_valid);
        end
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_after valid=%b exp=0000", bus.out_valid);
        end
        cycle();
        n_vec++;
        if (bus.out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_nostore valid=%b exp=0000", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [NOUT-1:0] ev;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_sel    = SEL_W'($urandom_range(0, NOUT-1));
            bus.in_data   = {$urandom, $urandom};
            bus.out_ready = NOUT'($urandom);
            flush         = ($urandom_range(0, 15) == 0);
            #1;
            n_vec++;
            if (bus.in_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_rdy i=%0d got=%b exp=%b", i, bus.in_ready, exp_ready());
            end
            cycle();
            ev = exp_valid();
            n_vec++;
            if (bus.out_valid !== ev) begin
                n_err++;
                $display("FAIL rand_valid i=%0d got=%b exp=%b", i, bus.out_valid, ev);
            end
            for (int k = 0; k < NOUT; k++) begin
                if (ev[k]) begin
                    n_vec++;
                    if (bus.out_data[k*WIDTH +: WIDTH] !== mq[k][0]) begin
                        n_err++;
                        $display("FAIL rand_data i=%0d ch=%0d got=%h exp=%h", i, k,
                                 bus.out_data[k*WIDTH +: WIDTH], mq[k][0]);
                    end
                end
            end
`ifdef DEMUX1_N_PIPE_CNT_EN
            for (int k = 0; k < NOUT; k++) begin
                n_vec++;
                if (acc_cnt[k*8 +: 8] !== mcnt[k]) begin
                    n_err++;
                    $display("FAIL rand_cnt i=%0d ch=%0d got=%0d exp=%0d", i, k, acc_cnt[k*8 +: 8], mcnt[k]);
                end
            end
`endif
        end
        idle_inputs();
        bus.out_ready = '1;
        cycle();
    endtask

`ifdef DEMUX1_N_PIPE_CNT_EN
    task automatic test_counters();
        idle_inputs();
        do_reset();
        bus.out_ready = 4'b1001;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        for (int i = 0; i < 257; i++) begin
            bus.in_data = 64'(i);
            #1;
            n_vec++;
            if (bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL cnt_rdy beat=%0d got=%b exp=1", i, bus.in_ready);
            end
            cycle();
        end
        bus.in_sel = 2'd3;
        for (int i = 0; i < 3; i++) cycle();
        n_vec++;
        if (acc_cnt[7:0] !== 8'd1 || acc_cnt[31:24] !== 8'd3) begin
            n_err++;
            $display("FAIL cnt_value ch0=%0d ch3=%0d exp 1/3", acc_cnt[7:0], acc_cnt[31:24]);
        end
        bus.in_sel = 2'd0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        cycle();
        n_vec++;
        if (acc_cnt[7:0] !== 8'd1 || acc_cnt[31:24] !== 8'd3 || acc_cnt[23:8] !== 16'd0) begin
            n_err++;
            $display("FAIL cnt_flush cnt=%h exp ch0=1 ch3=3 others 0", acc_cnt);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        do_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flush();
        test_random();
`ifdef DEMUX1_N_PIPE_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux1_n_pipe.md
Name: demux1_n_pipe

Overview:
- Registered 1-to-N demultiplexer with valid/ready handshakes. It is the splitting counterpart of the 2:1 mux primitive.
- Accepts one beat per cycle on a single input stream and steers it, by select, into one of NOUT per-channel holding registers.
- Used in the pipeline to dispatch a result or instruction bundle to one of several downstream consumers, for example functional-unit queues or writeback ports.
- Each channel back-pressures independently.

Parameters:
- WIDTH, 64, data bits per beat.
- SEL_W, 2, select width; NOUT = 2**SEL_W output channels (default 4).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all held beats (pipeline flush)
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready
- in_sel  input  SEL_W  destination channel of input beat
- in_data  input  WIDTH  input payload
- out_valid  output  NOUT  per-channel holding register full
- out_ready  input  NOUT  per-channel consumer accepts
- out_data  output  NOUT*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]

Behaviour:
- Reset (reset_n low, asynchronous, any time):
  - all out_valid = 0, out_data = 0.
  - in_ready = 0 while reset_n is low.
  - A beat in flight mid-operation is discarded.
- Per channel k, a single-entry holding register: full[k] drives out_valid[k]; data[k] drives the channel-k slice of out_data.
- Output transfer on channel k: out_valid[k] & out_ready[k] at a rising edge.
- in_ready (combinational) = ~flush & (~full[in_sel] | out_ready[in_sel]).
  - Depends only on the selected channel.
  - Does not depend on in_valid.
  - Other channels being full never stalls the input.
- Input accept = in_valid & in_ready. On accept:
  - data[in_sel] <= in_data.
  - full[in_sel] <= 1.
  - Latency 1: the beat appears on out_valid/out_data the cycle after acceptance.
- Same-cycle drain and refill on channel k (full, out_ready[k]=1, accept to k):
  - The new beat replaces the old one.
  - full[k] stays 1.
  - Full throughput of 1 beat/cycle per channel.
- Drain without refill on channel k: full[k] <= 0; data[k] holds its old value (don't care).
- Channels not selected and not draining: unchanged.
- flush = 1:
  - All full[k] <= 0 at the next edge.
  - in_ready = 0, so no beat is accepted.
  - Flush wins over any simultaneous accept or drain.
  - out_valid may still be 1 during the flush cycle; a consumer transfer in that cycle is legal and counts.
- Ordering:
  - Beats to the same channel leave in acceptance order.
  - No ordering is guaranteed across channels.
- Every in_sel value is valid (NOUT = 2**SEL_W).
- Inputs are assumed stable only around the clock edge; in_data and in_sel are don't-care when in_valid = 0.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data slice k does not change.

Optional Feature:
- Macro DEMUX1_N_PIPE_CNT_EN.
- When defined:
  - Adds output port acc_cnt, NOUT*8 bits.
  - Channel k has an 8-bit counter of input beats accepted for channel k; it wraps 255 -> 0.
  - Counters reset to 0 on reset_n low.
  - Counters are not cleared by flush.
  - A beat accepted is counted even if it is later flushed.
- When undefined: no port and no counters; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n low mid-stream with channel 2 full.
  - Required response: out_valid = 4'b0000 immediately (async); in_ready = 0.
  - After release with in_valid=0: out_valid stays 0.
- Single beat:
  - Stimulus: in_sel=1, in_data=64'hA5, out_ready=0.
  - Required response: next cycle out_valid = 4'b0010 and slice 1 = 64'hA5.
  - Second beat to sel=1 gives in_ready=0 and slice 1 holds 64'hA5.
  - Raising out_ready[1] gives in_ready=1.
- Independent back-pressure:
  - Stimulus: channel 0 full with out_ready[0]=0; send sel=3 data=64'h7.
  - Required response: accepted; out_valid = 4'b1001.
- Streaming:
  - Stimulus: 8 back-to-back beats to sel=2 (data 1..8) with out_ready[2]=1.
  - Required response: in_ready=1 every cycle; consumer sees 1..8 in order, one per cycle, 1-cycle latency.
- Flush collision:
  - Stimulus: channels 0 and 1 full; flush=1 with in_valid=1, sel=2.
  - Required response: in_ready=0; next cycle out_valid = 4'b0000; beat to channel 2 not stored.
- Counters (DEMUX1_N_PIPE_CNT_EN defined):
  - Stimulus: 257 accepted beats to sel=0, then 3 to sel=3, then a flush.
  - Required response: acc_cnt[7:0] = 1 and acc_cnt[31:24] = 3; values unchanged after the flush.
